serial_add_ctrl: RTL and testbench
==================================

# serial_add_ctrl

Bit-serial adder controller. It accepts two WIDTH-bit operands over a valid/ready handshake and drives a single `full_adder` instance one bit per cycle, LSB first, through a registered carry loop. It returns the WIDTH-bit sum and final carry over a second valid/ready handshake. It is the sequencing wrapper that turns the one-bit `full_adder` datapath into a multi-bit arithmetic unit, trading area for latency.

## Interface
- `WIDTH`, 8, operand/result width in bits; legal range 1..64
- `clk` input 1: sole clock; all state updates on posedge
- `rst` input 1: asynchronous, active-high reset
- `in_valid` input 1: operand packet valid
- `in_ready` output 1: controller can accept operands; high only in IDLE
- `a` input WIDTH: operand A; sampled on the accept edge
- `b` input WIDTH: operand B; sampled on the accept edge
- `c_in` input 1: carry-in to bit 0; sampled on the accept edge
- `out_valid` output 1: result valid; high only in DONE
- `out_ready` input 1: consumer accepts result
- `sum` output WIDTH: result; registered and stable while `out_valid` is high
- `c_out` output 1: carry out of bit WIDTH-1; registered
- `busy` output 1: high in RUN or DONE

## Operation
- Internal state: 2-bit FSM IDLE/RUN/DONE; operand shift registers `a_sh`, `b_sh`; `sum_sh`; carry flop `cy`; bit counter `cnt` of width $clog2(WIDTH+1).
- One `full_adder` instance: a=`a_sh[0]`, b=`b_sh[0]`, c_in=`cy`.
- IDLE, on `in_valid && in_ready`:
  - load `a_sh`=a, `b_sh`=b, `cy`=c_in
  - clear `cnt` and `sum_sh`
  - go to RUN
- IDLE with `in_valid` low: hold all state.
- RUN, each edge:
  - `sum_sh` <= {fa.sum, `sum_sh[WIDTH-1:1]`}
  - `a_sh` and `b_sh` shift right by 1
  - `cy` <= fa.c_out
  - `cnt` increments
  - on the edge where `cnt`==WIDTH-1, go to DONE
- RUN ignores `in_valid`, and `in_ready` stays low. No new operands are accepted mid-operation.
- DONE:
  - `sum`=`sum_sh`, `c_out`=`cy`
  - on `out_valid && out_ready`, go to IDLE
  - otherwise hold indefinitely with no change to `sum`/`c_out`
- Arithmetic: {c_out,sum} = a + b + c_in, computed modulo 2^(WIDTH+1), with no truncation of the carry.
- WIDTH=1: RUN lasts exactly one cycle.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `busy`=0, `sum`=0, `c_out`=0; FSM=IDLE; all internal registers 0.
- Latency: if the accept edge is T, `out_valid` rises after edge T+WIDTH. For WIDTH=8, that is 8 edges after accept.
- Result to next accept:
  - the DONE→IDLE transition takes one edge
  - `in_ready` is high on the following cycle
  - minimum issue interval is WIDTH+2 cycles
- `in_ready` is combinational from the state only, with no path from `in_valid`. `out_valid` is also state-only.
- Reset asserted mid-RUN or mid-DONE: the FSM goes to IDLE immediately (asynchronously). The operation is discarded and no result is emitted.
- `in_valid` asserted during RUN or DONE: no effect. The producer must hold the packet until `in_ready` is high.
- `out_ready` high before `out_valid`: no effect.

## Configuration
- `SERIAL_ADD_SUB_EN` defined:
  - adds port `sub` (input, 1), sampled on the accept edge
  - when `sub`=1, `b_sh` loads ~b and `cy` loads 1 (c_in is ignored), so sum = a − b modulo 2^WIDTH
  - `c_out`=1 means no borrow
  - when `sub`=0, behaviour is identical to the undefined case
- `SERIAL_ADD_SUB_EN` undefined: the `sub` port is absent and the block is add-only.

## Test plan
- Reset, then a=8'h5A, b=8'h3C, c_in=0 handshake → `out_valid` 8 edges after accept, `sum`=8'h96, `c_out`=0.
- a=8'hFF, b=8'h01, c_in=0 → `sum`=8'h00, `c_out`=1. Then a=8'hFF, b=8'h00, c_in=1 → `sum`=8'h00, `c_out`=1.
- Hold `out_ready`=0 for 5 cycles after `out_valid` → `sum`/`c_out` stable and `in_ready`=0 throughout. Pulse `out_ready` → IDLE next edge.
- Assert `in_valid` with new operands during RUN → ignored; the first result is unaffected. The second packet is accepted only once `in_ready`=1.
- Assert `rst` on the 4th RUN cycle → `out_valid`=0, `busy`=0, `in_ready`=1 immediately, `sum`=0. A fresh 8'h01+8'h01 then yields 8'h02.
- With `SERIAL_ADD_SUB_EN`: sub=1, a=8'h10, b=8'h01 → `sum`=8'h0F, `c_out`=1. Then a=8'h00, b=8'h01 → `sum`=8'hFF, `c_out`=0.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: feeds one full_adder LSB-first through a registered carry loop.
// Define SERIAL_ADD_SUB_EN to add the `sub` port (a - b via ~b and carry-in of 1).

module full_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);
  assign sum   = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic             cy_q, cy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fa_sum, fa_cout;
  logic [WIDTH-1:0] b_load;
  logic             cy_load;

  full_adder u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .c_in (cy_q),
    .sum  (fa_sum),
    .c_out(fa_cout)
  );

  // Operand B and carry-in as captured on the accept edge
`ifdef SERIAL_ADD_SUB_EN
  assign b_load  = sub ? ~b : b;
  assign cy_load = sub ? 1'b1 : c_in;
`else
  assign b_load  = b;
  assign cy_load = c_in;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      cy_q     <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      cy_q     <= cy_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    cy_d     = cy_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d   = a;
          b_sh_d   = b_load;
          cy_d     = cy_load;
          sum_sh_d = '0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        // New sum bit enters at the MSB; widened shift keeps WIDTH=1 legal
        sum_sh_d = WIDTH'({fa_sum, sum_sh_q} >> 1);
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        cy_d     = fa_cout;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum       = sum_sh_q;
  assign c_out     = cy_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl (WIDTH=8); covers the add-only and SERIAL_ADD_SUB_EN builds.

module tb_serial_add_ctrl;

  localparam int unsigned WIDTH = 8;
  localparam int          MAX_WAIT = 50;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             busy;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub;
`endif

  int n_vec  = 0;
  int n_fail = 0;

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .c_in     (c_in),
`ifdef SERIAL_ADD_SUB_EN
    .sub      (sub),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .c_out    (c_out),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Waits (bounded) for out_valid and returns the number of edges taken
  task automatic wait_done(output int edges);
    edges = 0;
    while (!out_valid && edges < MAX_WAIT) begin
      tick();
      edges++;
    end
  endtask

  task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                        input logic tc, input logic [WIDTH-1:0] es, input logic ec,
                        input int hold, input string tag);
    int n;
    a = ta; b = tb_v; c_in = tc; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < MAX_WAIT) begin
      tick();
      n++;
    end
    check({tag, ".ready"}, 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    check({tag, ".busy"}, 64'(busy), 64'd1);
    wait_done(n);
    check({tag, ".latency"}, 64'(n), 64'(WIDTH));
    check({tag, ".sum"}, 64'(sum), 64'(es));
    check({tag, ".c_out"}, 64'(c_out), 64'(ec));
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, ".hold_sum"}, 64'(sum), 64'(es));
      check({tag, ".hold_cout"}, 64'(c_out), 64'(ec));
      check({tag, ".hold_in_ready"}, 64'(in_ready), 64'd0);
      check({tag, ".hold_valid"}, 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, ".idle_valid"}, 64'(out_valid), 64'd0);
    check({tag, ".idle_ready"}, 64'(in_ready), 64'd1);
    check({tag, ".idle_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; c_in = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    sub = 1'b0;
`endif
    #2;
    check("rst.in_ready", 64'(in_ready), 64'd1);
    check("rst.out_valid", 64'(out_valid), 64'd0);
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.sum", 64'(sum), 64'd0);
    check("rst.c_out", 64'(c_out), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("post_rst.in_ready", 64'(in_ready), 64'd1);
    // out_ready early while idle has no effect
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("early_oready.busy", 64'(busy), 64'd0);

    run_op(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 0, "add5a3c");
    run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0, "addff01");
    run_op(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 0, "addff00c");
    run_op(8'h5A, 8'h3C, 1'b1, 8'h97, 1'b0, 5, "hold5");
    run_op(8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 0, "add8080c");

    // A second packet presented during RUN must not disturb the first
    a = 8'h12; b = 8'h34; c_in = 1'b0; in_valid = 1'b1;
    tick();
    a = 8'hF0; b = 8'h0F; c_in = 1'b1;
    tick();
    check("ign.in_ready", 64'(in_ready), 64'd0);
    wait_done(n);
    check("ign.latency", 64'(n), 64'(WIDTH - 1));
    check("ign.sum", 64'(sum), 64'h46);
    check("ign.c_out", 64'(c_out), 64'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("ign.idle_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    check("ign2.busy", 64'(busy), 64'd1);
    wait_done(n);
    check("ign2.latency", 64'(n), 64'(WIDTH));
    check("ign2.sum", 64'(sum), 64'h00);
    check("ign2.c_out", 64'(c_out), 64'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("ign2.idle", 64'(in_ready), 64'd1);

    // Asynchronous reset on the 4th RUN cycle discards the operation
    a = 8'hAA; b = 8'h55; c_in = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    check("mid.busy_before", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    check("mid.out_valid", 64'(out_valid), 64'd0);
    check("mid.busy", 64'(busy), 64'd0);
    check("mid.in_ready", 64'(in_ready), 64'd1);
    check("mid.sum", 64'(sum), 64'd0);
    check("mid.c_out", 64'(c_out), 64'd0);
    #2;
    rst = 1'b0;
    tick();
    check("mid.stay_idle", 64'(busy), 64'd0);
    run_op(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 0, "after_rst");

`ifdef SERIAL_ADD_SUB_EN
    sub = 1'b1;
    run_op(8'h10, 8'h01, 1'b0, 8'h0F, 1'b1, 0, "sub1001");
    run_op(8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 0, "sub0001");
    sub = 1'b0;
    run_op(8'h10, 8'h01, 1'b0, 8'h11, 1'b0, 0, "nosub");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
